jam_cost_loader: RTL and testbench

- Upstream companion of the JAM assignment engine.
- Accepts a 64-entry worker/job cost matrix over a valid/ready stream and stores it in a register file.
- Holds the engine in reset while loading, then serves the engine's combinational W/J cost lookups.
- Captures the engine's final MinCost/MatchCount when Valid rises and holds them for the host until the next start.

---
 rtl/jam_pkg.sv | 24 ++
 rtl/jam_cost_rf.sv | 24 ++
 rtl/jam_cost_loader.sv | 112 +++++++++++
 tb/tb_jam_cost_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared sizing, state encoding and matrix indexing for the JAM cost loader.
package jam_pkg;

  localparam int N      = 8;
  localparam int COST_W = 7;
  localparam int MIN_W  = 10;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = $clog2(N);
  localparam int ADDR_W = $clog2(N * N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  // Row-major flattening: worker is the outer dimension, job the inner one.
  function automatic logic [ADDR_W-1:0] idx(input logic [IDX_W-1:0] w,
                                            input logic [IDX_W-1:0] j);
    return ADDR_W'(w) * ADDR_W'(N) + ADDR_W'(j);
  endfunction

endpackage

// File: rtl/jam_cost_rf.sv
// N*N x COST_W cost register file: one synchronous write port, one
// combinational read port. Contents are deliberately not reset.
module jam_cost_rf
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [N*N];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_loader.sv
// Streams a cost matrix into the register file, holds the JAM engine in reset
// while loading, serves its lookups, and captures its final result.
module jam_cost_loader
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  output logic              jam_rst,
  input  logic [IDX_W-1:0]  jam_w,
  input  logic [IDX_W-1:0]  jam_j,
  output logic [COST_W-1:0] jam_cost,
  input  logic              jam_valid,
  input  logic [MIN_W-1:0]  jam_min_cost,
  input  logic [CNT_W-1:0]  jam_match_count,
  output logic              busy,
  output logic              res_valid,
  output logic [MIN_W-1:0]  res_min_cost,
  output logic [CNT_W-1:0]  res_match_count
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N * N - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              in_ready_q;
  logic              jam_rst_q;
  logic              res_valid_q;
  logic [MIN_W-1:0]  res_min_q;
  logic [CNT_W-1:0]  res_cnt_q;
  logic              accept;

  // in_ready_q is only ever high in LOAD, so it alone qualifies a write.
  assign accept = in_valid && in_ready_q;

  // The final accept lands in RUN with in_ready and jam_rst dropping together,
  // so the engine's reset is held through the last LOAD cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      jam_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_min_q   <= '0;
      res_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (cnt_q == LastAddr) begin
              state_q    <= RUN;
              in_ready_q <= 1'b0;
              jam_rst_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (jam_valid) begin
            state_q     <= DONE;
            jam_rst_q   <= 1'b1;
            res_valid_q <= 1'b1;
            res_min_q   <= jam_min_cost;
            res_cnt_q   <= jam_match_count;
          end
        end
        DONE: begin
          if (start) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_min_q   <= '0;
            res_cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign jam_rst         = jam_rst_q;
  assign busy            = (state_q == LOAD) || (state_q == RUN);
  assign res_valid       = res_valid_q;
  assign res_min_cost    = res_min_q;
  assign res_match_count = res_cnt_q;

  jam_cost_rf u_rf (
    .CLK   (CLK),
    .we    (accept),
    .waddr (cnt_q),
    .wdata (in_data),
    .raddr (idx(jam_w, jam_j)),
    .rdata (jam_cost)
  );

endmodule

// File: tb/tb_jam_cost_loader.sv
// Scoreboard bench for jam_cost_loader: accepted words and expected results
// are queued as stimulus is driven and popped when the DUT presents them.
module tb_jam_cost_loader;
  import jam_pkg::*;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic              in_valid;
  logic [COST_W-1:0] in_data;
  logic              in_ready;
  logic              jam_rst;
  logic [IDX_W-1:0]  jam_w;
  logic [IDX_W-1:0]  jam_j;
  logic [COST_W-1:0] jam_cost;
  logic              jam_valid;
  logic [MIN_W-1:0]  jam_min_cost;
  logic [CNT_W-1:0]  jam_match_count;
  logic              busy;
  logic              res_valid;
  logic [MIN_W-1:0]  res_min_cost;
  logic [CNT_W-1:0]  res_match_count;

  typedef struct {
    logic [MIN_W-1:0] minCost;
    logic [CNT_W-1:0] matchCount;
  } res_t;

  logic [COST_W-1:0] expQ [$];
  res_t              resQ [$];
  int                compared   = 0;
  int                mismatched = 0;

  always #5 CLK = ~CLK;

  jam_cost_loader dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .jam_rst         (jam_rst),
    .jam_w           (jam_w),
    .jam_j           (jam_j),
    .jam_cost        (jam_cost),
    .jam_valid       (jam_valid),
    .jam_min_cost    (jam_min_cost),
    .jam_match_count (jam_match_count),
    .busy            (busy),
    .res_valid       (res_valid),
    .res_min_cost    (res_min_cost),
    .res_match_count (res_match_count)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams 64 words of value (k*mult+off)%128, optionally with random stalls
  // and a stray start at entry 20; each accepted word is queued as expected.
  task automatic load_matrix(input bit stall, input bit startMid,
                             input int mult, input int off);
    int acc = 0;
    int cyc = 0;
    bit v;
    bit took;
    logic [COST_W-1:0] d;
    expQ.delete();
    while (acc < N * N && cyc < 2000) begin
      v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = COST_W'((acc * mult + off) % 128);
      in_valid = v;
      in_data  = v ? d : ~d;
      start    = startMid && (acc == 20);
      compared++;
      if (in_ready !== 1'b1 || jam_rst !== 1'b1 || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL load_handshake entry %0d: in_ready=%b jam_rst=%b busy=%b, required 1 1 1",
                 acc, in_ready, jam_rst, busy);
      end
      took = v && in_ready;
      step();
      if (took) begin
        expQ.push_back(d);
        acc++;
      end
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    compared++;
    if (acc != N * N) begin
      mismatched++;
      $display("[TB] FAIL load_timeout: got %0d accepts, required %0d", acc, N * N);
    end
    compared++;
    if (in_ready !== 1'b0 || jam_rst !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL enter_run: in_ready=%b jam_rst=%b busy=%b, required 0 0 1",
               in_ready, jam_rst, busy);
    end
  endtask

  // Walks every (w,j) in row-major order, popping the expected word per lookup.
  task automatic check_mem(input string tag);
    logic [COST_W-1:0] e;
    for (int w = 0; w < N; w++) begin
      for (int j = 0; j < N; j++) begin
        jam_w = IDX_W'(w);
        jam_j = IDX_W'(j);
        #2;
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL %s scoreboard empty at w=%0d j=%0d, got %0d", tag, w, j, jam_cost);
        end else begin
          e = expQ.pop_front();
          if (jam_cost !== e) begin
            mismatched++;
            $display("[TB] FAIL %s cost w=%0d j=%0d: got %0d, required %0d", tag, w, j, jam_cost, e);
          end
        end
      end
    end
    step();
  endtask

  // Pulses jam_valid in RUN (optionally with start) and checks the held result.
  task automatic test_capture(input int minC, input int cnt, input bit withStart);
    res_t e;
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (busy !== 1'b1 || jam_rst !== 1'b0 || res_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL start_in_run: busy=%b jam_rst=%b res_valid=%b, required 1 0 0",
               busy, jam_rst, res_valid);
    end
    jam_min_cost    = MIN_W'(minC);
    jam_match_count = CNT_W'(cnt);
    jam_valid       = 1'b1;
    start           = withStart;
    resQ.push_back('{MIN_W'(minC), CNT_W'(cnt)});
    step();
    jam_valid = 1'b0;
    start     = 1'b0;
    e = resQ.pop_front();
    compared++;
    if (res_valid !== 1'b1 || res_min_cost !== e.minCost || res_match_count !== e.matchCount) begin
      mismatched++;
      $display("[TB] FAIL capture: got valid=%b min=%0d cnt=%0d, required 1 %0d %0d",
               res_valid, res_min_cost, res_match_count, e.minCost, e.matchCount);
    end
    compared++;
    if (jam_rst !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL capture_state: jam_rst=%b busy=%b in_ready=%b, required 1 0 0",
               jam_rst, busy, in_ready);
    end
    jam_min_cost    = 10'd123;
    jam_match_count = 4'd9;
    jam_valid       = 1'b1;
    repeat (3) step();
    jam_valid = 1'b0;
    compared++;
    if (res_valid !== 1'b1 || res_min_cost !== e.minCost || res_match_count !== e.matchCount) begin
      mismatched++;
      $display("[TB] FAIL hold: got valid=%b min=%0d cnt=%0d, required 1 %0d %0d",
               res_valid, res_min_cost, res_match_count, e.minCost, e.matchCount);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    jam_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++;
      if (jam_rst !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
          res_min_cost !== '0 || res_match_count !== '0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle cycle %0d: jam_rst=%b in_ready=%b busy=%b res_valid=%b min=%0d cnt=%0d, required 1 0 0 0 0 0",
                 i, jam_rst, in_ready, busy, res_valid, res_min_cost, res_match_count);
      end
    end
    jam_valid = 1'b0;
  endtask

  task automatic test_full_load();
    pulse_start();
    load_matrix(1'b0, 1'b0, 1, 0);
    jam_w = 3'd3;
    jam_j = 3'd5;
    #2;
    compared++;
    if (jam_cost !== 7'd29) begin
      mismatched++;
      $display("[TB] FAIL lookup_w3_j5: got %0d, required 29", jam_cost);
    end
    check_mem("full_load");
    test_capture(668, 1, 1'b0);
  endtask

  task automatic test_restart_backpressure();
    pulse_start();
    compared++;
    if (res_valid !== 1'b0 || res_min_cost !== '0 || res_match_count !== '0 ||
        in_ready !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL restart: res_valid=%b min=%0d cnt=%0d in_ready=%b busy=%b, required 0 0 0 1 1",
               res_valid, res_min_cost, res_match_count, in_ready, busy);
    end
    load_matrix(1'b1, 1'b1, 37, 5);
    in_valid = 1'b1;
    in_data  = 7'h55;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (in_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL extra_word cycle %0d: in_ready=%b, required 0", i, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    check_mem("backpressure");
    test_capture(500, 8, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    load_matrix(1'b0, 1'b0, 3, 11);
    RST = 1'b1;
    step();
    RST = 1'b0;
    compared++;
    if (jam_rst !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0 ||
        res_min_cost !== '0 || res_match_count !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_run: jam_rst=%b busy=%b in_ready=%b res_valid=%b min=%0d cnt=%0d, required 1 0 0 0 0 0",
               jam_rst, busy, in_ready, res_valid, res_min_cost, res_match_count);
    end
    repeat (2) step();
    pulse_start();
    load_matrix(1'b1, 1'b0, 5, 2);
    check_mem("after_reset");
    test_capture(300, 7, 1'b0);
  endtask

  initial begin
    RST             = 1'b1;
    start           = 1'b0;
    in_valid        = 1'b0;
    in_data         = '0;
    jam_w           = '0;
    jam_j           = '0;
    jam_valid       = 1'b0;
    jam_min_cost    = '0;
    jam_match_count = '0;
    #1;
    test_reset();
    test_full_load();
    test_restart_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
